// File: rtl/alu_result_stage.sv
// ALU result/flag stage: picks the unit output for the issued opcode, derives Z/N/C/V,
// and queues result+flags in a small power-of-two FIFO toward writeback.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [WIDTH-1:0]         and_f,
  input  logic [WIDTH-1:0]         or_f,
  input  logic [WIDTH-1:0]         xor_f,
  input  logic [WIDTH-1:0]         sum_f,
  input  logic                     cout,
  input  logic                     x_msb,
  input  logic                     y_msb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         f,
  output logic                     zf,
  output logic                     nf,
  output logic                     cf,
  output logic                     vf,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_ADD = 2'b11} op_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          new_e, head;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    new_e = '0;
    case (op_e'(op))
      OP_AND:  new_e.res = and_f;
      OP_OR:   new_e.res = or_f;
      OP_XOR:  new_e.res = xor_f;
      default: new_e.res = sum_f;
    endcase
    new_e.z = (new_e.res == '0);
    new_e.n = new_e.res[WIDTH-1];
    if (op_e'(op) == OP_ADD) begin
      new_e.c = cout;
      new_e.v = (x_msb == y_msb) & (sum_f[WIDTH-1] != x_msb);
    end
  end

  always_comb begin
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      if (push) mem_q[wr_q] <= new_e;
    end
  end

  // Head outputs are gated to zero whenever the queue is empty.
  always_comb begin
    head = out_valid ? mem_q[rd_q] : '0;
    f    = head.res;
    zf   = head.z;
    nf   = head.n;
    cf   = head.c;
    vf   = head.v;
  end

  assign count = count_q;

endmodule
